// File: rtl/uart_operand_collector.sv
// uart_operand_collector
//   Frames the UART RX byte stream into two little-endian operands (A, then B)
//   and holds the pair for the adder behind a valid/ready handshake. A partial
//   frame is dropped after TIMEOUT_CYCLES idle cycles. Bytes that arrive while a
//   completed pair is waiting are dropped and flagged.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   rx_data_i, rx_valid_i   received byte + one-cycle strobe
//   op_ready_i              consumer accepts the pair
//   a_o, b_o, cin_o         adder operands, carry-in (always 0)
//   op_valid_o              a_o/b_o hold a complete pair
//   busy_o                  partial frame in progress
//   timeout_o, overrun_o    one-cycle event pulses
module uart_operand_collector #(
  parameter int OPERAND_BYTES  = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  input  logic                       op_ready_i,
  output logic [8*OPERAND_BYTES-1:0] a_o,
  output logic [8*OPERAND_BYTES-1:0] b_o,
  output logic                       cin_o,
  output logic                       op_valid_o,
  output logic                       busy_o,
  output logic                       timeout_o,
  output logic                       overrun_o
);

  localparam int IDX_W = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OPERAND_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_HOLD} state_t;

  state_t                              state;
  logic [IDX_W-1:0]                    idx;
  logic [CNT_W-1:0]                    cnt;
  // Byte-lane view of the operands so a byte index selects a lane directly.
  logic [OPERAND_BYTES-1:0][7:0]       a_q, b_q;

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign cin_o = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_valid_i) begin
            a_q[0] <= rx_data_i;
            busy_o <= 1'b1;
            // Single-byte operands finish A on the first byte.
            if (OPERAND_BYTES == 1) begin
              idx   <= '0;
              state <= S_LOAD_B;
            end else begin
              idx   <= IDX_W'(1);
              state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (rx_valid_i) begin
            // An accepted byte always wins over a timeout in the same cycle.
            cnt <= '0;
            if (state == S_LOAD_A) a_q[idx] <= rx_data_i;
            else                   b_q[idx] <= rx_data_i;
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (state == S_LOAD_A) begin
                state <= S_LOAD_B;
              end else begin
                state      <= S_HOLD;
                busy_o     <= 1'b0;
                op_valid_o <= 1'b1;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (cnt == CNT_LAST) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          cnt <= '0;
          // Bytes are dropped even on the transfer edge itself.
          if (rx_valid_i) overrun_o <= 1'b1;
          if (op_ready_i) begin
            state      <= S_IDLE;
            op_valid_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
